// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

    // Code 7 is reserved and treated like NOP.
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mdu_state_e;
endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the operand-mux stage and the MDU.
interface mdu_if #(parameter int WIDTH = mdu_pkg::MDU_WIDTH) ();
    import mdu_pkg::*;

    logic             start;
    mdu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix.
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and one-cycle MTHI/MTLO.
// Optional MDU_ABORT_EN adds an abort input that cancels an in-flight operation.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITERS = WIDTH
) (
    input logic   clk,
    input logic   rst_n,
`ifdef MDU_ABORT_EN
    input logic   abort,
`endif
    mdu_if.slave  bus
);
    localparam int CW = $clog2(ITERS + 1);

    mdu_state_e         state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r;
    logic               busy_r, done_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic req_md, div_op, sgn_op, div0, sa, sb, fix;
    assign req_md = bus.start && (state == IDLE) && (bus.op inside {MULT, MULTU, DIV, DIVU});
    assign div_op = bus.op inside {DIV, DIVU};
    assign sgn_op = bus.op inside {MULT, DIV};
    assign div0   = div_op && (bus.b == '0);
    // Divide by zero keeps the raw dividend: the restoring loop then yields all-ones / a.
    assign sa     = sgn_op && !div0 && bus.a[WIDTH-1];
    assign sb     = sgn_op && bus.b[WIDTH-1];
    assign fix    = (state == FIX);

    // Multiply step: conditional add into the upper half, then shift right.
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   psum;
    assign addend = acc[0] ? opb : '0;
    assign psum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Divide step: {rem, next dividend bit} minus divisor; keep it if no borrow.
    logic [WIDTH:0]   rsh;
    logic [WIDTH+1:0] trial;
    assign rsh   = acc[2*WIDTH-1:WIDTH-1];
    assign trial = {1'b0, rsh} - {2'b00, opb};

    logic [2*WIDTH-1:0] acc_nxt;
    always_comb begin
        acc_nxt = {psum, acc[WIDTH-1:1]};
        if (is_div)
            acc_nxt = trial[WIDTH+1] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] n0_x, n0_y;
    logic [WIDTH-1:0]   n1_x, n1_y;
    logic               n0_neg, n1_neg;
    assign n0_x   = fix ? (is_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc)
                        : {{WIDTH{1'b0}}, bus.a};
    assign n0_neg = fix ? neg_q : sa;
    assign n1_x   = fix ? acc[2*WIDTH-1:WIDTH] : bus.b;
    assign n1_neg = fix ? neg_r : sb;

    mdu_abs_neg #(.W(2*WIDTH)) u_neg0 (.x(n0_x), .neg(n0_neg), .y(n0_y));
    mdu_abs_neg #(.W(WIDTH))   u_neg1 (.x(n1_x), .neg(n1_neg), .y(n1_y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
`ifdef MDU_ABORT_EN
            if (abort && busy_r) begin
                state  <= IDLE;
                busy_r <= 1'b0;
            end else
`endif
            case (state)
                IDLE: begin
                    if (req_md) begin
                        acc    <= {{WIDTH{1'b0}}, n0_y[WIDTH-1:0]};
                        opb    <= n1_y;
                        cnt    <= '0;
                        is_div <= div_op;
                        neg_q  <= sa ^ sb;
                        neg_r  <= div_op & sa;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end else if (bus.start && bus.op == MTHI) begin
                        hi_r <= bus.a;
                    end else if (bus.start && bus.op == MTLO) begin
                        lo_r <= bus.a;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITERS - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo_r <= n0_y[WIDTH-1:0];
                        hi_r <= n1_y;
                    end else begin
                        {hi_r, lo_r} <= n0_y;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model plus literal result checks.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef MDU_ABORT_EN
        .abort (1'b0),
`endif
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // {hi, lo} straight from the architectural definition of each op.
    function automatic logic [63:0] ref_result(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = a;
        ib = b;
        case (op)
            MULT:  return sa * sb;
            MULTU: return {32'h0, a} * {32'h0, b};
            DIVU:  return (b == 0) ? {a, DIV0_LO} : {a % b, a / b};
            DIV: begin
                if (b == 0)                               return {a, DIV0_LO};
                if (a == 32'h8000_0000 && b == '1)        return {32'h0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: return 64'h0;
        endcase
    endfunction

    logic [W-1:0] m_hi, m_lo;
    logic [63:0]  m_res;
    logic         m_busy, m_done;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_res <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_hi, m_lo} <= m_res;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (bus.start) begin
                if (bus.op inside {MULT, MULTU, DIV, DIVU}) begin
                    m_res  <= ref_result(bus.op, bus.a, bus.b);
                    m_left <= W + 1;
                    m_busy <= 1'b1;
                end else if (bus.op == MTHI) begin
                    m_hi <= bus.a;
                end else if (bus.op == MTLO) begin
                    m_lo <= bus.a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model busy", bus.busy, m_busy);
            chk("model done", bus.done, m_done);
            chk("model hi",   bus.hi,   m_hi);
            chk("model lo",   bus.lo,   m_lo);
        end
    end

    task automatic run_op(input string nm, input mdu_op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, " busy@1"}, bus.busy, 1);
        cyc = 1;
        seen = 0;
        while (!seen && cyc < LAT + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == LAT - 1) chk({nm, " busy@last"}, bus.busy, 1);
            if (bus.done) seen = 1;
        end
        chk({nm, " done_cycle"}, cyc, LAT);
        chk({nm, " busy@done"}, bus.busy, 0);
        chk({nm, " hi"}, bus.hi, eh);
        chk({nm, " lo"}, bus.lo, el);
    endtask

    task automatic mt_seq(input bit do_reset);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = MTHI; bus.a = 32'h1234_5678; bus.b = '0;
        @(negedge clk);
        chk("mthi hi", bus.hi, 32'h1234_5678);
        chk("mthi busy", bus.busy, 0);
        bus.op = MULTU; bus.a = 32'd5; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        seen = 0;
        while (!seen && cyc < LAT + 20) begin
            if (cyc == 10) begin bus.start = 1'b1; bus.op = MTLO; bus.a = 32'hAAAA_AAAA; end
            if (cyc == 11) bus.start = 1'b0;
            if (do_reset && cyc == 15) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst busy", bus.busy, 0);
                chk("rst hi",   bus.hi,   0);
                chk("rst lo",   bus.lo,   0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1;
        end
        chk("mt seq done_cycle", cyc, LAT);
        chk("mt seq hi", bus.hi, 32'h0);
        chk("mt seq lo", bus.lo, 32'h23);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.op = NOP; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset hi",   bus.hi,   0);
        chk("reset lo",   bus.lo,   0);
        rst_n = 1'b1;

        run_op("mult neg",   MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu max",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div neg",    DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu zero",  DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div ovf",    DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div negb",   DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu basic", DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
        run_op("mult min",   MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div zero s", DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("mult m1",    MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

        // Reserved and NOP codes must leave everything untouched.
        @(negedge clk);
        bus.start = 1'b1; bus.op = mdu_op_e'(3'd7); bus.a = 32'h5555_5555; bus.b = 32'h3;
        @(negedge clk);
        bus.op = NOP;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rsvd busy", bus.busy, 0);
        chk("rsvd hi",   bus.hi,   32'hFFFF_FFFF);
        chk("rsvd lo",   bus.lo,   32'hFFFF_FFF9);

        mt_seq(1'b0);
        mt_seq(1'b1);
        run_op("post rst", MULTU, 32'd5, 32'd7, 32'h0, 32'h23);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative MIPS multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the ALU operand-B mux.
- Operand a comes from rs. Operand b is the 32-bit mux output.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- HI/LO are read combinationally by the MFHI/MFLO writeback path.

Parameters:
WIDTH, 32, operand and HI/LO width
ITERS, WIDTH, shift/add or shift/subtract iterations per operation (equals WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; op, a, b are sampled on the same edge
op  input  3  operation code; encodings in mdu_pkg
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (ALU operand-mux output)
busy  output  1  high while a MULT/DIV is in progress
done  output  1  one-cycle pulse when HI/LO take a new MULT/DIV result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, hi=0, lo=0. FSM=IDLE. All internal accumulators, counter and sign flags are 0.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - latch operands; for signed ops, latch magnitudes plus result-sign flags.
  - counter=0; next state CALC; busy=1 from the next cycle.
- IDLE, start=1, op in {MTHI, MTLO}:
  - hi<=a (MTHI) or lo<=a (MTLO) on that edge.
  - stay IDLE; busy stays 0; no done pulse.
- IDLE, start=1, op=NOP or reserved code: ignored.
- CALC: one iteration per cycle for ITERS cycles, then FIX.
  - multiply: shift-add on a 2*WIDTH accumulator.
  - divide: restoring shift-subtract producing quotient and remainder.
- FIX:
  - apply sign correction; write hi/lo; assert done for one cycle.
  - next state IDLE; busy=0 in the same cycle done=1.
- Latency: start edge at cycle 0; busy=1 in cycles 1..ITERS+1; hi/lo valid and done=1 in cycle ITERS+2 (34 for WIDTH=32).
- Multiply: {hi,lo} = 64-bit product.
  - MULT: two's-complement operands.
  - MULTU: unsigned operands.
- Divide: lo=quotient, hi=remainder.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: lo=all ones, hi=a. Same latency; done still pulses.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- start while busy=1: ignored, including MTHI/MTLO. The in-flight result completes unaffected.
- hi/lo hold their previous values throughout CALC until the FIX write.
- rst_n low mid-operation: immediate return to the reset state; the partial result is discarded.

Optional Feature:
- Macro MDU_ABORT_EN.
- Defined:
  - adds input port abort (1 bit), sampled each edge.
  - abort=1 while busy=1: return to IDLE on that edge; hi/lo unchanged; no done pulse; busy=0 next cycle.
  - abort takes priority over the FIX write.
  - abort=1 in IDLE has no effect; a start on the same edge is still accepted.
- Undefined: no abort port; every accepted operation completes.

Decomposition:
- Package mdu_pkg:
  - op encodings: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 reserved.
  - FSM state typedef {IDLE, CALC, FIX}.
  - constants WIDTH default and DIV0_LO (all ones).
- Sub-module mdu_abs_neg (combinational):
  - conditional two's-complement negate, shared by operand-magnitude and result-sign-fix logic.
  - instantiated twice in mult_div_unit.

Test Plan:
- MULT, a=0xFFFFFFFE, b=0x00000003 -> busy cycles 1..33; done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU, a=0x00000064, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, done pulses.
- Signed overflow, DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MULTU 5x7 started next cycle, then MTLO a=0xAAAAAAAA issued at cycle 10:
  - hi=0x12345678 after one edge with no busy.
  - MTLO ignored; final hi=0, lo=0x23.
  - rst_n pulsed low at cycle 15 of a rerun -> busy=0, hi=lo=0 immediately.
